// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 front end (padder and chaining logic).
package sha256_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    EMIT = 2'd2
  } pad_state_e;

  localparam logic [7:0] PAD_MARKER  = 8'h80;
  localparam int         BLOCK_WORDS = 16;
  localparam int         LEN_FIELD_W = 64;

  // Initial hash value H(0), consumed by the chaining logic on a first block
  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6A09E667, 32'h BB67AE85, 32'h3C6EF372, 32'hA54FF53A,
    32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
  };

endpackage

// File: rtl/sha256_tail_word.sv
// Masks the unused low bytes of a partial message word and places the 0x80 marker
// in the first unused byte; full (or empty) words pass through untouched.
module sha256_tail_word
  import sha256_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  nbytes_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = word_i;
    case (nbytes_i)
      3'd1:    word_o = {word_i[31:24], PAD_MARKER, 16'h0000};
      3'd2:    word_o = {word_i[31:16], PAD_MARKER, 8'h00};
      3'd3:    word_o = {word_i[31:8], PAD_MARKER};
      default: word_o = word_i;
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: packs 32-bit words into 512-bit blocks, appends marker and length.
// Define SHA256_PAD_BYTESWAP_EN to accept little-endian input words.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  data_in,
  input  logic [2:0]   data_bytes,
  input  logic         data_valid,
  input  logic         data_last,
  output logic         data_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last
);

  pad_state_e       state_q, state_d;
  logic [4:0]       widx_q, widx_d, widx_pad;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      buf_q [BLOCK_WORDS];
  logic [31:0]      buf_d [BLOCK_WORDS];
  logic             pad_done_q, pad_done_d;
  logic             last_seen_q, last_seen_d;
  logic             first_pending_q, first_pending_d;
  logic             blk_last_q, blk_last_d;

  logic [31:0]            word_be, tail_word;
  logic [2:0]             nbytes;
  logic [LEN_FIELD_W-1:0] len_field;

`ifdef SHA256_PAD_BYTESWAP_EN
  assign word_be = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};
`else
  assign word_be = data_in;
`endif

  assign nbytes    = (data_bytes > 3'd4) ? 3'd4 : data_bytes;
  assign len_field = LEN_FIELD_W'(len_q);

  sha256_tail_word u_tail (
    .word_i   (word_be),
    .nbytes_i (nbytes),
    .word_o   (tail_word)
  );

  always_comb begin
    state_d         = state_q;
    widx_d          = widx_q;
    widx_pad        = widx_q;
    len_d           = len_q;
    buf_d           = buf_q;
    pad_done_d      = pad_done_q;
    last_seen_d     = last_seen_q;
    first_pending_d = first_pending_q;
    blk_last_d      = blk_last_q;
    case (state_q)
      FILL: begin
        if (data_valid) begin
          if (nbytes != 3'd0) begin
            buf_d[widx_q[3:0]] = tail_word;
            widx_d             = widx_q + 5'd1;
            if (nbytes < 3'd4) pad_done_d = 1'b1;
          end
          len_d = len_q + LEN_W'({nbytes, 3'b000});
          if (data_last) last_seen_d = 1'b1;
          if (widx_d == 5'd16) begin
            state_d    = EMIT;
            blk_last_d = 1'b0;
          end else if (data_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        if (!pad_done_q) begin
          buf_d[widx_q[3:0]] = {PAD_MARKER, 24'h000000};
          widx_pad           = widx_q + 5'd1;
          pad_done_d         = 1'b1;
        end
        widx_d = widx_pad;
        // Length only fits if w14/w15 are still free; otherwise it spills to a fresh block
        if (widx_pad <= 5'd14) begin
          buf_d[14]  = len_field[63:32];
          buf_d[15]  = len_field[31:0];
          blk_last_d = 1'b1;
        end else begin
          blk_last_d = 1'b0;
        end
        state_d = EMIT;
      end
      EMIT: begin
        if (blk_ready) begin
          buf_d           = '{default: '0};
          widx_d          = 5'd0;
          first_pending_d = 1'b0;
          if (blk_last_q) begin
            state_d         = FILL;
            len_d           = '0;
            pad_done_d      = 1'b0;
            last_seen_d     = 1'b0;
            first_pending_d = 1'b1;
          end else if (last_seen_q) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= FILL;
      widx_q          <= '0;
      len_q           <= '0;
      buf_q           <= '{default: '0};
      pad_done_q      <= 1'b0;
      last_seen_q     <= 1'b0;
      first_pending_q <= 1'b1;
      blk_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      widx_q          <= widx_d;
      len_q           <= len_d;
      buf_q           <= buf_d;
      pad_done_q      <= pad_done_d;
      last_seen_q     <= last_seen_d;
      first_pending_q <= first_pending_d;
      blk_last_q      <= blk_last_d;
    end
  end

  assign data_ready = reset && (state_q == FILL);
  assign blk_valid  = reset && (state_q == EMIT);
  assign blk_first  = blk_valid && first_pending_q;
  assign blk_last   = blk_valid && blk_last_q;

  generate
    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_pack
      assign blk_data[511-32*gi -: 32] = reset ? buf_q[gi] : 32'h0;
    end
  endgenerate

endmodule
